// File: rtl/ahb_sram_slave_p_if.sv
// rtl/ahb_sram_slave_p_if.sv - AHB-Lite bus bundle between the interconnect and the SRAM slave
interface ahb_sram_slave_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 20
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    // Interconnect side: drives the request, the write data and the bus-level hready.
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave_p.sv
// rtl/ahb_sram_slave_p.sv - parametrised AHB-Lite SRAM slave; optional ERROR response under AHB_SRAM_SLAVE_P_ERR_EN
module ahb_sram_slave_p #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 20,
    parameter int DEPTH_WORDS = 262144,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              hresetn,
    ahb_sram_slave_p_if.slave bus
);
    localparam int          NB         = DATA_W / 8;
    localparam int          OFF_W      = $clog2(NB);
    localparam int          IDX_FULL_W = ADDR_W - OFF_W;
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  MAX_SIZE   = 3'(OFF_W);
    localparam logic [2:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [31:0] DEPTH_U    = DEPTH_WORDS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             wait_cnt;
    logic [2:0]             wait_cnt_nxt;

    logic                   dp_valid;
    logic                   dp_write;
    logic [IDX_W-1:0]       dp_idx;
    logic [OFF_W-1:0]       dp_off;
    logic [2:0]             dp_size;

    logic                   ready_int;
    logic                   accept;
    logic                   addr_err;
    logic                   complete;
    logic [IDX_FULL_W-1:0]  idx_full;
    logic [IDX_W-1:0]       idx_wrap;
    logic [2:0]             sz_eff;
    logic [NB-1:0]          byte_en;
    logic                   unused_bits;

    logic [DATA_W-1:0]      mem [DEPTH_WORDS];

    // A new address phase is only taken while this slave is not stretching
    // a data phase, so the registered request of a pending phase is never lost.
    assign ready_int = (state == S_IDLE) || (state == S_ERR2);
    assign accept    = bus.hsel & bus.htrans[1] & bus.hready;
    assign complete  = ready_int & dp_valid;

    assign idx_full  = bus.haddr[ADDR_W-1:OFF_W];
    assign idx_wrap  = IDX_W'(32'(idx_full) % DEPTH_U);

`ifdef AHB_SRAM_SLAVE_P_ERR_EN
    // Flag out-of-range words, oversize transfers and size-misaligned addresses.
    always_comb begin
        addr_err = 1'b0;
        if (32'(idx_full) >= DEPTH_U) begin
            addr_err = 1'b1;
        end
        if (bus.hsize > MAX_SIZE) begin
            addr_err = 1'b1;
        end else begin
            for (int i = 0; i < OFF_W; i++) begin
                if (bus.haddr[i] && (3'(i) < bus.hsize)) begin
                    addr_err = 1'b1;
                end
            end
        end
    end

    assign bus.hresp = (state == S_ERR1) || (state == S_ERR2);
`else
    assign addr_err  = 1'b0;
    assign bus.hresp = 1'b0;
`endif

    assign bus.hreadyout = ready_int;

    // State register and wait-state counter.
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic: stretch OKAY phases by WAIT_STATES, errors take two cycles.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE, S_ERR2: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 3'd1;
                end
            end
            S_ERR1: begin
                state_nxt = S_ERR2;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the address phase; an erroring transfer opens no data phase.
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_off   <= '0;
            dp_size  <= 3'd0;
        end else if (ready_int) begin
            dp_valid <= accept & ~addr_err;
            if (accept) begin
                dp_write <= bus.hwrite;
                dp_idx   <= idx_wrap;
                dp_off   <= bus.haddr[OFF_W-1:0];
                dp_size  <= bus.hsize;
            end
        end
    end

    // A lane is written when it falls in the same size-aligned block as the offset;
    // oversize requests collapse to a full-width access.
    always_comb begin
        sz_eff = (dp_size > MAX_SIZE) ? MAX_SIZE : dp_size;
        for (int i = 0; i < NB; i++) begin
            byte_en[i] = ((OFF_W'(i) >> sz_eff) == (dp_off >> sz_eff));
        end
    end

    // Commit write data on the edge that ends the completing cycle.
    always_ff @(posedge clk) begin
        if (complete && dp_write) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    mem[dp_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.hrdata = (dp_valid && !dp_write) ? mem[dp_idx] : '0;

    assign unused_bits = ^{bus.htrans[0], bus.hburst};
endmodule

// File: tb/tb_ahb_sram_slave_p.sv
// tb/tb_ahb_sram_slave_p.sv - randomized and directed bench for ahb_sram_slave_p against a byte-array model
module tb_ahb_sram_slave_p;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        hresetn = 1'b0;
    logic        sel;
    logic        stall;
    logic        hsel_v;
    logic        hwrite_v;
    logic [19:0] haddr_v;
    logic [1:0]  htrans_v;
    logic [2:0]  hsize_v;
    logic [2:0]  hburst_v;
    logic [31:0] hwdata_v;
    logic        ro;
    logic        rsp;
    logic [31:0] rd;

    always #5 clk = ~clk;

    ahb_sram_slave_p_if #(.DATA_W(32), .ADDR_W(20)) bus0 ();
    ahb_sram_slave_p_if #(.DATA_W(32), .ADDR_W(20)) bus3 ();

    assign bus0.hsel   = hsel_v & (sel == 1'b0);
    assign bus0.haddr  = haddr_v;
    assign bus0.htrans = htrans_v;
    assign bus0.hwrite = hwrite_v;
    assign bus0.hsize  = hsize_v;
    assign bus0.hburst = hburst_v;
    assign bus0.hwdata = hwdata_v;
    assign bus0.hready = bus0.hreadyout & ~stall;

    assign bus3.hsel   = hsel_v & (sel == 1'b1);
    assign bus3.haddr  = haddr_v;
    assign bus3.htrans = htrans_v;
    assign bus3.hwrite = hwrite_v;
    assign bus3.hsize  = hsize_v;
    assign bus3.hburst = hburst_v;
    assign bus3.hwdata = hwdata_v;
    assign bus3.hready = bus3.hreadyout & ~stall;

    assign ro  = sel ? bus3.hreadyout : bus0.hreadyout;
    assign rsp = sel ? bus3.hresp     : bus0.hresp;
    assign rd  = sel ? bus3.hrdata    : bus0.hrdata;

    ahb_sram_slave_p #(.DATA_W(32), .ADDR_W(20), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk     (clk),
        .hresetn (hresetn),
        .bus     (bus0.slave)
    );

    ahb_sram_slave_p #(.DATA_W(32), .ADDR_W(20), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk     (clk),
        .hresetn (hresetn),
        .bus     (bus3.slave)
    );

    typedef struct {
        logic        w;
        logic [19:0] a;
        logic [2:0]  sz;
        logic [31:0] d;
    } txn_t;

    txn_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mb [2][DEPTH*4];
    logic [31:0] last_rd;
    logic        last_rsp;
    int          last_lows;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int msize(input logic [2:0] sz);
        return (sz > 3'd2) ? 2 : int'(sz);
    endfunction

    function automatic logic exp_err(input logic [19:0] a, input logic [2:0] sz);
`ifdef AHB_SRAM_SLAVE_P_ERR_EN
        return (int'(a >> 2) >= DEPTH) || (sz > 3'd2) || ((int'(a) % (1 << int'(sz))) != 0);
`else
        return (^{a, sz}) & 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_word(input int s, input logic [19:0] a);
        int idx;
        idx = int'(a >> 2) % DEPTH;
        return {mb[s][idx*4+3], mb[s][idx*4+2], mb[s][idx*4+1], mb[s][idx*4]};
    endfunction

    task automatic model_write(input int s, input logic [19:0] a, input logic [2:0] sz, input logic [31:0] d);
        int n;
        int base;
        int idx;
        int lane;
        n    = 1 << msize(sz);
        base = int'(a) & ~(n - 1);
        idx  = (base >> 2) % DEPTH;
        lane = base % 4;
        for (int b = 0; b < n; b++) begin
            mb[s][idx*4 + lane + b] = d[8*(lane+b) +: 8];
        end
    endtask

    task automatic push(input logic w, input logic [19:0] a, input logic [2:0] sz, input logic [31:0] d);
        txn_t t;
        t.w = w; t.a = a; t.sz = sz; t.d = d;
        q.push_back(t);
    endtask

    // Drives the queued transfers back to back (each address phase overlaps the
    // previous data phase) and checks every data phase against the model.
    task automatic run_q();
        txn_t cur;
        logic have;
        logic e;
        int   lows;
        int   ws;
        have = 1'b0;
        cur  = '{1'b0, 20'd0, 3'd0, 32'd0};
        ws   = sel ? 3 : 0;
        for (int k = 0; k <= q.size(); k++) begin
            if (k < q.size()) begin
                hsel_v = 1'b1; htrans_v = 2'b10; haddr_v = q[k].a;
                hwrite_v = q[k].w; hsize_v = q[k].sz;
            end else begin
                hsel_v = 1'b0; htrans_v = 2'b00;
            end
            hwdata_v = have ? cur.d : 32'd0;
            e = have ? exp_err(cur.a, cur.sz) : 1'b0;
            lows = 0;
            @(negedge clk);
            while (ro !== 1'b1 && lows < 20) begin
                if (have) check("wait_hresp", rsp, e);
                lows++;
                @(negedge clk);
            end
            if (lows >= 20) check("hreadyout_timeout", ro, 1'b1);
            if (have) begin
                last_lows = lows;
                last_rsp  = rsp;
                check("latency", lows, e ? 1 : ws);
                check("hresp", rsp, e);
                if (cur.w) begin
                    check("wr_hrdata", rd, 32'd0);
                    if (!e) model_write(int'(sel), cur.a, cur.sz, cur.d);
                end else begin
                    last_rd = rd;
                    check("rd_data", rd, e ? 32'd0 : model_word(int'(sel), cur.a));
                end
            end else begin
                check("idle_hresp", rsp, 1'b0);
            end
            @(posedge clk);
            #1;
            if (k < q.size()) begin
                cur = q[k];
                have = 1'b1;
            end else begin
                have = 1'b0;
            end
        end
        hwdata_v = 32'd0;
        q.delete();
    endtask

    initial begin
        logic [19:0] ra;
        logic [2:0]  rs;
        sel = 1'b0; stall = 1'b0; hsel_v = 1'b0; htrans_v = 2'b00; haddr_v = 20'd0;
        hwrite_v = 1'b0; hsize_v = 3'd0; hburst_v = 3'd0; hwdata_v = 32'd0;
        last_rd = 32'd0; last_rsp = 1'b0; last_lows = 0;

        #12;
        check("rst_hreadyout0", bus0.hreadyout, 1'b1);
        check("rst_hresp0", bus0.hresp, 1'b0);
        check("rst_hrdata0", bus0.hrdata, 32'd0);
        check("rst_hreadyout3", bus3.hreadyout, 1'b1);
        check("rst_hrdata3", bus3.hrdata, 32'd0);
        @(posedge clk);
        #1 hresetn = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < DEPTH; i++) push(1'b1, 20'(i * 4), 3'd2, $urandom);
            run_q();
        end

        sel = 1'b0;
        push(1'b1, 20'h100, 3'd2, 32'hDEADBEEF);
        push(1'b0, 20'h100, 3'd2, 32'd0);
        run_q();
        check("deadbeef", last_rd, 32'hDEADBEEF);

        push(1'b1, 20'h40, 3'd2, 32'h11223344);
        push(1'b1, 20'h42, 3'd0, 32'h00AA0000);
        push(1'b0, 20'h40, 3'd2, 32'd0);
        run_q();
        check("byte_write", last_rd, 32'h11AA3344);

        push(1'b1, 20'h40, 3'd1, 32'h0000BEEF);
        push(1'b0, 20'h40, 3'd2, 32'd0);
        run_q();
        check("half_write", last_rd, 32'h11AABEEF);

        push(1'b1, 20'h80, 3'd2, 32'h5);
        push(1'b0, 20'h80, 3'd2, 32'd0);
        run_q();
        check("wr_then_rd", last_rd, 32'h5);

        sel = 1'b1;
        push(1'b0, 20'h100, 3'd2, 32'd0);
        run_q();
        check("ws3_latency", last_lows, 3);

        stall = 1'b1; hsel_v = 1'b1; htrans_v = 2'b10; haddr_v = 20'h200;
        hwrite_v = 1'b0; hsize_v = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", ro, 1'b1);
            check("stall_hrdata", rd, 32'd0);
        end
        @(posedge clk);
        #1 hsel_v = 1'b0; htrans_v = 2'b00; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ignored_ready", ro, 1'b1);
        end
        @(posedge clk);
        #1;

        sel = 1'b0;
        push(1'b0, 20'h1000, 3'd2, 32'd0);
        run_q();
`ifdef AHB_SRAM_SLAVE_P_ERR_EN
        check("oor_hresp", last_rsp, 1'b1);
        check("oor_latency", last_lows, 1);
        check("oor_hrdata", last_rd, 32'd0);
`else
        check("wrap_hresp", last_rsp, 1'b0);
        check("wrap_rd", last_rd, model_word(0, 20'h0));
`endif
        push(1'b1, 20'h1000, 3'd2, 32'hFFFFFFFF);
        push(1'b0, 20'h0, 3'd2, 32'd0);
        run_q();

        sel = 1'b1;
        push(1'b1, 20'h200, 3'd2, 32'h12345678);
        run_q();
        hsel_v = 1'b1; htrans_v = 2'b10; haddr_v = 20'h200; hwrite_v = 1'b1; hsize_v = 3'd2;
        @(posedge clk);
        #1 hsel_v = 1'b0; htrans_v = 2'b00; hwdata_v = 32'hCAFEF00D;
        @(negedge clk);
        check("rst_in_wait", ro, 1'b0);
        #2 hresetn = 1'b0;
        #1;
        check("rst_mid_ready", ro, 1'b1);
        check("rst_mid_hresp", rsp, 1'b0);
        @(posedge clk);
        #1 hresetn = 1'b1; hwdata_v = 32'd0;
        push(1'b0, 20'h200, 3'd2, 32'd0);
        run_q();
        check("rst_keeps_word", last_rd, 32'h12345678);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 150; i++) begin
                rs = 3'($urandom_range(0, 3));
                ra = 20'($urandom_range(0, 1100) * 4 + $urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0 && rs <= 3'd2) ra = ra & ~20'((1 << int'(rs)) - 1);
                push(1'($urandom_range(0, 1)), ra, rs, $urandom);
            end
            run_q();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave_p.md
Name: ahb_sram_slave_p

Overview:
- Parametrised AHB-Lite SRAM slave; next generation of the fixed 32-bit, 1 MB, zero-wait RAM slave.
- Adds configurable data width and depth, HSIZE byte-lane writes, programmable wait states and a proper HREADY input.
- Optionally adds a two-cycle ERROR response.
- Sits on the system AHB matrix as a generic on-chip memory (frame buffers, scratch).

Parameters:
- DATA_W, 32, bus/word width in bits; legal values 32 or 64.
- ADDR_W, 20, width of haddr in bits.
- DEPTH_WORDS, 262144, number of DATA_W words implemented; must be ≤ 2^(ADDR_W-log2(DATA_W/8)).
- WAIT_STATES, 0, hreadyout-low cycles per OKAY data phase; range 0..7.

Ports:
- clk  in  1  AHB clock; all state on rising edge.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  byte address.
- htrans  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type; accepted, not used.
- hwdata  in  DATA_W  write data, valid in data phase.
- hready  in  1  bus-level HREADY from the interconnect.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_W  read data.

Behaviour:
- Reset values (async on hresetn low): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, data-phase-valid=0. Memory contents are not reset.
- Address-phase acceptance: accept = hsel & htrans[1] & hready. On accept, register:
  - word index = haddr >> log2(DATA_W/8);
  - byte offset;
  - hsize;
  - hwrite.
- IDLE/BUSY transfers, or hsel=0, start no data phase. The slave holds hreadyout=1, hresp=0.
- Byte enables are derived from the registered offset and hsize:
  - 8-bit → 1 lane; 16-bit → 2 lanes; 32-bit → 4 lanes; 64-bit (DATA_W=64 only) → 8 lanes.
  - Lane position = offset aligned down to the size.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hreadyout=1. On accept of an OKAY transfer:
    - WAIT_STATES>0 → go to WAIT and load counter = WAIT_STATES-1; hreadyout=0 from the next cycle.
    - WAIT_STATES=0 → the data phase completes in the next cycle with hreadyout=1 (stay IDLE).
  - WAIT: hreadyout=0. Counter decrements each cycle. At 0, go to IDLE; hreadyout=1 in the following cycle, which completes the data phase.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1 → IDLE.
- Data-phase completion is the cycle in which hreadyout=1 and data-phase-valid=1.
  - Write: on the clock edge ending that cycle, memory[index] is updated with hwdata on the enabled lanes only.
  - Read: hrdata = memory[index], combinational from the registered index. Unselected lanes still return the full word. hrdata=0 outside read data phases.
- Pipelining: a new address phase may be accepted in the completing cycle of the previous data phase.
- Back-to-back write then read of the same address returns the new data. The write commits at the edge before the read data phase, so no bypass is needed.
- Latency: reads and writes take WAIT_STATES+1 cycles per data phase; throughput is 1/(WAIT_STATES+1).
- Address phases presented while hready=0 are ignored.
- hreset mid-WAIT/ERR: the pending write is discarded and the FSM returns to IDLE with reset values.

Optional Feature:
- Macro: AHB_SRAM_SLAVE_P_ERR_EN.
- Defined: an accepted transfer gets ERROR (IDLE→ERR1→ERR2, no memory update, hrdata=0) if any of:
  - word index ≥ DEPTH_WORDS;
  - hsize > log2(DATA_W/8);
  - address not aligned to hsize.
- Not defined: hresp is tied to 0 and ERR1/ERR2 are never entered.
  - Word index wraps modulo DEPTH_WORDS.
  - Oversize hsize is treated as a full-width access.
  - Misaligned offset bits below the size are ignored.

Test Plan:
- DATA_W=32, WAIT_STATES=0: write 0xDEADBEEF to 0x100, then read 0x100 → hrdata=0xDEADBEEF in the read data phase; hreadyout=1 throughout; hresp=0.
- Write word 0x11223344 to 0x40; byte write 0xAA (hsize=0) to 0x42; read 0x40 → 0x11AA3344. Halfword write 0xBEEF to 0x40; read 0x40 → 0x11AABEEF.
- WAIT_STATES=3: single read → exactly 3 cycles of hreadyout=0 and then 1 cycle of hreadyout=1 with valid data. NONSEQ driven while hready=0 → ignored.
- Pipelined write 0x5 then read of the same address in consecutive address phases → read returns 0x5.
- With ERR_EN, DEPTH_WORDS=1024: read of haddr=0x1000 → hreadyout 0 then 1, hresp=1 for both cycles, memory unchanged. Without ERR_EN: same access reads word 0 (wrap).
- Assert hresetn low during WAIT of a write → hreadyout=1, hresp=0 immediately; target word keeps its old value.
